// File: rtl/button_event_scheduler_if.sv
// Head-of-queue event handshake between the scheduler (master) and its consumer (slave).
// An event transfers at a rising edge where evt_valid=1 and evt_ready=1; evt_ready with evt_valid=0 is ignored.
interface button_event_scheduler_if;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic       evt_ready;

   modport master (output evt_valid, output evt_code, input evt_ready);
   modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/button_event_scheduler.sv
// Latches button press pulses, arbitrates them round-robin into an event FIFO, flags coalesced presses.
// Optional macro BTN_EVT_DROP_COUNT_EN adds the saturating drop_count output.
module button_event_scheduler #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       global_clock,
   input  logic       reset,
   input  logic [3:0] btn_pulse,
   button_event_scheduler_if.master evt,
   output logic [3:0] pending,
   output logic       evt_overflow
`ifdef BTN_EVT_DROP_COUNT_EN
   ,
   output logic [7:0] drop_count
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [3:0]       pending_q = '0, pending_d;
   logic [1:0]       rr_ptr_q  = '0, rr_ptr_d;
   logic             ovf_q     = 1'b0, ovf_d;
   logic             valid_q   = 1'b0;
   logic [PTR_W-1:0] wr_ptr_q  = '0, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q  = '0, rd_ptr_d;
   logic [CNT_W-1:0] count_q   = '0, count_d;
   logic [1:0]       mem_q [FIFO_DEPTH] = '{default: '0};

   logic       full;
   logic       push;
   logic       pop;
   logic       sel_found;
   logic [1:0] sel_idx;
   logic [1:0] cand;
   logic [3:0] clr_mask;
   logic [3:0] coalesced;

   always_comb begin
      full      = (count_q == CNT_W'(FIFO_DEPTH));
      sel_found = 1'b0;
      sel_idx   = rr_ptr_q;
      cand      = rr_ptr_q;
      // Scan from farthest to nearest so the first pending bit at or after rr_ptr wins.
      for (int k = 3; k >= 0; k--) begin
         cand = rr_ptr_q + 2'(k);
         if (pending_q[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
      push      = sel_found && !full;
      pop       = valid_q && evt.evt_ready;
      clr_mask  = push ? (4'b0001 << sel_idx) : 4'b0000;
      coalesced = btn_pulse & pending_q & ~clr_mask;
      pending_d = (pending_q & ~clr_mask) | btn_pulse;
      ovf_d     = ovf_q | (|coalesced);
      rr_ptr_d  = push ? (sel_idx + 2'd1) : rr_ptr_q;
      wr_ptr_d  = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d  = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge global_clock) begin
      if (reset) begin
         pending_q <= '0;
         rr_ptr_q  <= '0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         pending_q <= pending_d;
         rr_ptr_q  <= rr_ptr_d;
         ovf_q     <= ovf_d;
         valid_q   <= (count_d != '0);
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         if (push) mem_q[wr_ptr_q] <= sel_idx;
      end
   end

   assign evt.evt_valid = valid_q;
   assign evt.evt_code  = mem_q[rd_ptr_q];
   assign pending       = pending_q;
   assign evt_overflow  = ovf_q;

`ifdef BTN_EVT_DROP_COUNT_EN
   logic [7:0] drop_q = '0;
   logic [2:0] drop_inc;
   logic [8:0] drop_sum;

   always_comb begin
      drop_inc = 3'(coalesced[0]) + 3'(coalesced[1]) + 3'(coalesced[2]) + 3'(coalesced[3]);
      drop_sum = {1'b0, drop_q} + 9'(drop_inc);
   end

   // Saturates at 255; only reset clears it.
   always_ff @(posedge global_clock) begin
      if (reset) drop_q <= '0;
      else       drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: directed vector table, directed multi-cycle sequences, random vs. model.
// Build with BTN_EVT_DROP_COUNT_EN defined to also check drop_count.
module tb_button_event_scheduler;
   localparam int DEPTH = 4;

   logic       global_clock;
   logic       reset;
   logic [3:0] btn_pulse;
   logic [3:0] pending;
   logic       evt_overflow;
`ifdef BTN_EVT_DROP_COUNT_EN
   logic [7:0] drop_count;
`endif

   button_event_scheduler_if evt_if ();

   button_event_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
      .global_clock (global_clock),
      .reset        (reset),
      .btn_pulse    (btn_pulse),
      .evt          (evt_if),
      .pending      (pending),
      .evt_overflow (evt_overflow)
`ifdef BTN_EVT_DROP_COUNT_EN
      ,
      .drop_count   (drop_count)
`endif
   );

   initial global_clock = 1'b0;
   always #5 global_clock = ~global_clock;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: pending set, FIFO contents as a queue, rotating start index.
   logic [1:0] exp_q[$];
   bit         m_pend[4];
   int         m_rr;
   bit         m_ovf;
   int         m_drop;

   typedef struct {
      logic       rst;
      logic [3:0] btn;
      logic       rdy;
      logic       e_valid;
      logic [1:0] e_code;
      logic       chk_code;
      logic [3:0] e_pend;
      logic       e_ovf;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic rst, input logic [3:0] btn, input logic rdy);
      int  pushed;
      bit  do_pop;
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < 4; i++) m_pend[i] = 0;
         m_rr = 0; m_ovf = 0; m_drop = 0;
         return;
      end
      do_pop = (exp_q.size() > 0) && rdy;
      pushed = -1;
      if (exp_q.size() < DEPTH) begin
         for (int k = 0; k < 4; k++) begin
            if (pushed < 0 && m_pend[(m_rr + k) % 4]) pushed = (m_rr + k) % 4;
         end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (pushed >= 0) begin
         exp_q.push_back(2'(pushed));
         m_pend[pushed] = 0;
         m_rr = (pushed + 1) % 4;
      end
      for (int i = 0; i < 4; i++) begin
         if (btn[i]) begin
            if (m_pend[i]) begin
               m_ovf = 1;
               if (m_drop < 255) m_drop++;
            end else begin
               m_pend[i] = 1;
            end
         end
      end
   endtask

   function automatic logic [3:0] model_pend();
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = m_pend[i];
      return p;
   endfunction

   // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
   task automatic apply(input logic rst, input logic [3:0] btn, input logic rdy);
      reset = rst;
      btn_pulse = btn;
      evt_if.evt_ready = rdy;
      model_step(rst, btn, rdy);
      @(posedge global_clock);
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".valid"}, 32'(evt_if.evt_valid), 32'(exp_q.size() != 0));
      check({tag, ".pending"}, 32'(pending), 32'(model_pend()));
      check({tag, ".overflow"}, 32'(evt_overflow), 32'(m_ovf));
      if (exp_q.size() != 0) check({tag, ".code"}, 32'(evt_if.evt_code), 32'(exp_q[0]));
`ifdef BTN_EVT_DROP_COUNT_EN
      check({tag, ".drop"}, 32'(drop_count), 32'(m_drop));
`endif
   endtask

   task automatic add(input logic rst, input logic [3:0] btn, input logic rdy, input logic ev,
                      input logic [1:0] ec, input logic cc, input logic [3:0] ep, input logic eo);
      vec_t v;
      v = '{rst, btn, rdy, ev, ec, cc, ep, eo};
      vecs.push_back(v);
   endtask

   initial begin
      logic [1:0] got[$];
      logic [1:0] want[6];
      logic [3:0] rb;
      logic       rr;
      logic       rs;

      reset = 1'b0;
      btn_pulse = 4'b0000;
      evt_if.evt_ready = 1'b0;
      #2;
      check("powerup.valid", 32'(evt_if.evt_valid), 32'd0);
      check("powerup.pending", 32'(pending), 32'd0);
      check("powerup.overflow", 32'(evt_overflow), 32'd0);

      //   rst btn      rdy  valid code chk  pend     ovf
      add(1, 4'b0000, 0,   0,    0,   1,   4'b0000, 0);  // reset
      add(0, 4'b0001, 0,   0,    0,   0,   4'b0001, 0);  // single press latched
      add(0, 4'b0000, 0,   1,    0,   1,   4'b0000, 0);  // queued one edge later
      add(0, 4'b0000, 0,   1,    0,   1,   4'b0000, 0);  // held stable
      add(1, 4'b0000, 0,   0,    0,   1,   4'b0000, 0);
      add(0, 4'b1111, 1,   0,    0,   0,   4'b1111, 0);  // all four at once, consumer ready
      add(0, 4'b0000, 1,   1,    0,   1,   4'b1110, 0);
      add(0, 4'b0000, 1,   1,    1,   1,   4'b1100, 0);
      add(0, 4'b0000, 1,   1,    2,   1,   4'b1000, 0);
      add(0, 4'b0000, 1,   1,    3,   1,   4'b0000, 0);
      add(0, 4'b0000, 1,   0,    0,   0,   4'b0000, 0);
      add(1, 4'b0000, 0,   0,    0,   1,   4'b0000, 0);
      add(0, 4'b0111, 0,   0,    0,   0,   4'b0111, 0);
      add(0, 4'b0000, 0,   1,    0,   1,   4'b0110, 0);
      add(0, 4'b0100, 0,   1,    0,   1,   4'b0100, 1);  // re-press of un-pushed button 2
      add(0, 4'b0000, 0,   1,    0,   1,   4'b0000, 1);  // three events queued
      add(1, 4'b0010, 1,   0,    0,   1,   4'b0000, 0);  // reset beats pulse and pop
      add(0, 4'b0000, 0,   0,    0,   1,   4'b0000, 0);
      add(0, 4'b0001, 0,   0,    0,   0,   4'b0001, 0);
      add(0, 4'b0001, 0,   1,    0,   1,   4'b0001, 0);  // press during its own push: kept
      add(0, 4'b0000, 0,   1,    0,   1,   4'b0000, 0);

      for (int n = 0; n < vecs.size(); n++) begin
         apply(vecs[n].rst, vecs[n].btn, vecs[n].rdy);
         check($sformatf("vec%0d.valid", n), 32'(evt_if.evt_valid), 32'(vecs[n].e_valid));
         check($sformatf("vec%0d.pending", n), 32'(pending), 32'(vecs[n].e_pend));
         check($sformatf("vec%0d.overflow", n), 32'(evt_overflow), 32'(vecs[n].e_ovf));
         if (vecs[n].chk_code)
            check($sformatf("vec%0d.code", n), 32'(evt_if.evt_code), 32'(vecs[n].e_code));
      end

      // Six presses against a four-deep queue: two wait in pending, none lost.
      apply(1, 4'b0000, 0);
      apply(0, 4'b1111, 0);
      for (int n = 0; n < 4; n++) apply(0, 4'b0000, 0);
      apply(0, 4'b0011, 0);
      apply(0, 4'b0000, 0);
      check("full.pending", 32'(pending), 32'(4'b0011));
      check("full.valid", 32'(evt_if.evt_valid), 32'd1);
      check("full.overflow", 32'(evt_overflow), 32'd0);
      want = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      got.delete();
      for (int n = 0; n < 30 && got.size() < 6; n++) begin
         if (evt_if.evt_valid) got.push_back(evt_if.evt_code);
         apply(0, 4'b0000, 1);
      end
      check("drain.count", 32'(got.size()), 32'd6);
      for (int n = 0; n < 6; n++)
         if (n < got.size()) check($sformatf("drain.order%0d", n), 32'(got[n]), 32'(want[n]));
      check("drain.pending", 32'(pending), 32'd0);
      check("drain.valid", 32'(evt_if.evt_valid), 32'd0);

      // Coalescing with a full queue, then drop counter saturation.
      apply(1, 4'b0000, 0);
      apply(0, 4'b1111, 0);
      for (int n = 0; n < 4; n++) apply(0, 4'b0000, 0);
      apply(0, 4'b0100, 0);
      check("coal.pending", 32'(pending), 32'(4'b0100));
      check("coal.ovf_before", 32'(evt_overflow), 32'd0);
      apply(0, 4'b0100, 0);
      check("coal.ovf_after", 32'(evt_overflow), 32'd1);
      check("coal.pending_kept", 32'(pending), 32'(4'b0100));
`ifdef BTN_EVT_DROP_COUNT_EN
      check("coal.drop1", 32'(drop_count), 32'd1);
`endif
      for (int n = 0; n < 300; n++) apply(0, 4'b0100, 0);
      check("coal.head", 32'(evt_if.evt_code), 32'd0);
`ifdef BTN_EVT_DROP_COUNT_EN
      check("coal.drop_sat", 32'(drop_count), 32'd255);
`endif
      check_model("coal.model");

      // Random traffic against the reference model.
      apply(1, 4'b0000, 0);
      check_model("rnd.reset");
      for (int n = 0; n < 3000; n++) begin
         rb = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         rr = ($urandom_range(0, 3) != 0);
         if (n % 500 > 250) rr = ($urandom_range(0, 5) == 0);
         rs = ($urandom_range(0, 199) == 0);
         apply(rs, rb, rr);
         check_model($sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
